multi_code_display_ctrl: RTL and testbench
==========================================

Name: multi_code_display_ctrl

Overview:
- Registered, parametrised multi-mode code converter driving a bank of 7-segment digits.
- Top digit shows a mode glyph; the remaining digits show the switch value in hex, decimal or BCD.
- Decimal uses a sequential double-dabble engine with a busy flag.
- Displayed segments change only when a conversion completes, so they never glitch mid-conversion.
- Sits between board switches/buttons and the 7-segment pins; replaces the single-nibble combinational converter.

Parameters:
- DATA_W, 8: switch word width. Must be a multiple of 4 and at least 4.
- NUM_DIGITS, 4: total digits. Digit NUM_DIGITS-1 is the prefix; the rest are value digits. Elaboration error if NUM_DIGITS-1 < DATA_W/4.
- ACTIVE_LOW, 1: when 1, the seg output is the bitwise inverse of the glyph.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn  in  3  mode buttons, active-low
- sw  in  DATA_W  unsigned input value
- seg  out  7*NUM_DIGITS  digit d at seg[7d+6:7d], bit order GFEDCBA (bit 0 = A); digit 0 is rightmost
- busy  out  1  conversion in progress
- overflow  out  1  displayed value is saturated or invalid

Behaviour:
- Reset: mode = OFF; all digits blank (seg all 1s when ACTIVE_LOW); busy = 0; overflow = 0; sw_q = 0; state = IDLE; last-converted tag invalidated.
- Input registers:
  - sw_q <= sw every cycle.
  - btn patterns 110 -> HEX, 101 -> DEC, 011 -> BCD, registered into mode.
  - Any other pattern (none, or several pressed) holds the current mode. The mode is sticky.
- FSM states: IDLE, CONV, LOAD.
- IDLE:
  - If {mode, sw_q} differs from the last-converted tag, capture the operand and the tag.
  - Go to CONV if mode == DEC, otherwise LOAD.
  - If mode == OFF: go to LOAD, which blanks all digits.
- CONV (double dabble):
  - Shift register is 4*(NUM_DIGITS-1) BCD bits plus DATA_W binary bits. Shift counter counts 0..DATA_W-1.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift left 1.
  - After DATA_W cycles, go to LOAD.
  - If sw_q or mode changes while in CONV: abort to IDLE next cycle. IDLE then restarts with the new tag, so a stale result is never loaded.
- LOAD: write all seg registers in one cycle, update overflow, then go to IDLE.
- busy = (state != IDLE).
- Latency: sw stable before edge N is sampled into sw_q at edge N.
  - HEX, BCD, OFF: seg updated at edge N+2.
  - DEC: seg updated at edge N+DATA_W+2.
- Prefix glyphs: HEX "H" 1110110; DEC "d" 1011110; BCD "b" 1111100; OFF blank 0000000.
- HEX content:
  - Value digits 0..DATA_W/4-1 hold the hex nibbles; higher value digits are blank.
  - overflow = 0.
- DEC content:
  - Value digits show the decimal value with leading zeros.
  - If sw >= 10^(NUM_DIGITS-1): all value digits show "-" (1000000) and overflow = 1.
- BCD content:
  - sw is treated as packed BCD, nibble i shown on digit i.
  - Any nibble > 9 is clamped to show "9" and sets overflow = 1.
  - Higher value digits are blank.
- A reset asserted mid-conversion wins: the reset values apply on that edge and the in-progress result is discarded.

Decomposition:
- Package multi_code_pkg:
  - mode enum {OFF, HEX, DEC, BCD};
  - button pattern constants;
  - glyph constants GLYPH_H, GLYPH_D, GLYPH_B, GLYPH_DASH, GLYPH_BLANK;
  - state enum {IDLE, CONV, LOAD}.
- Sub-module seg7_glyph: combinational 4-bit nibble to 7-bit glyph, 0-F. It is instantiated per value digit in the LOAD path.

Test Plan:
- rst held 2 cycles, then released with btn = 111 -> seg all 1s, busy = 0, overflow = 0, mode OFF.
- DATA_W = 8, NUM_DIGITS = 4: btn 110 pulse, sw = 0xA7 -> after 2 edges seg (active-high view) = {H, blank, A, 7}; overflow = 0; busy high for exactly 1 cycle.
- btn 101, sw = 255 -> busy for 9 cycles; at edge N+10 digits = {d, 2, 5, 5}. sw = 7 -> {d, 0, 0, 7}.
- btn 011, sw = 0x4C -> {b, blank, 4, 9}, overflow = 1. sw = 0x38 -> {b, blank, 3, 8}, overflow = 0.
- DEC with sw changed from 200 to 45 on the 4th CONV cycle -> 200 is never displayed; final {d, 0, 4, 5}. With NUM_DIGITS = 3, sw = 123 -> {d, -, -}, overflow = 1.
- Assert rst during CONV -> next edge seg blank, busy = 0. btn 000 or 100 while in HEX -> mode stays HEX.

Source files
------------

// File: rtl/multi_code_pkg.sv
// multi_code_pkg: shared modes, FSM states, button patterns and glyphs for the multi-code display
package multi_code_pkg;
  typedef enum logic [1:0] {OFF, HEX, DEC, BCD} mode_t;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam logic [2:0] BTN_HEX = 3'b110;
  localparam logic [2:0] BTN_DEC = 3'b101;
  localparam logic [2:0] BTN_BCD = 3'b011;
  localparam logic [6:0] GLYPH_H = 7'b1110110;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
endpackage

// File: rtl/multi_code_display_ctrl_glyph.sv
// seg7_glyph: hex nibble to active-high GFEDCBA glyph
module seg7_glyph (
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  assign glyph = LUT[nib];
endmodule

// File: rtl/multi_code_display_ctrl.sv
// multi_code_display_ctrl: mode-selectable hex/decimal/BCD driver for a registered 7-segment bank
module multi_code_display_ctrl
  import multi_code_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              btn,
  input  logic [DATA_W-1:0]       sw,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    overflow
);
  localparam int VD = NUM_DIGITS - 1;
  localparam int HD = DATA_W / 4;
  localparam int BW = 4 * VD;
  localparam int PW = DATA_W + BW;
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  if (DATA_W < 4 || DATA_W % 4 != 0 || VD < HD) begin : g_bad_params
    $error("multi_code_display_ctrl: DATA_W must be a multiple of 4 and fit in NUM_DIGITS-1 digits");
  end
  function automatic logic [PW-1:0] pow10(input int n);
    logic [PW-1:0] p;
    p = PW'(1);
    for (int i = 0; i < n; i++) p = p * PW'(10);
    return p;
  endfunction
  localparam logic [PW-1:0] DEC_LIMIT = pow10(VD);
  mode_t                   mode_q, mode_d, tag_mode_q, tag_mode_d;
  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       sw_q, op_q, op_d;
  logic                    tag_vld_q, tag_vld_d;
  logic [PW-1:0]           dd_q, dd_d, dd_adj;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    ovf_q, ovf_d, bcd_ovf, dec_ovf, changed;
  logic [6:0]              prefix;
  logic [VD-1:0][6:0]      val_seg;
  assign dec_ovf = PW'(op_q) >= DEC_LIMIT;
  assign changed = !tag_vld_q || mode_q != tag_mode_q || sw_q != op_q;
  assign prefix  = tag_mode_q == HEX ? GLYPH_H : tag_mode_q == DEC ? GLYPH_D :
                   tag_mode_q == BCD ? GLYPH_B : GLYPH_BLANK;
  always_comb begin
    bcd_ovf = 1'b0;
    for (int i = 0; i < HD; i++) bcd_ovf = bcd_ovf | (op_q[4*i +: 4] > 4'd9);
    dd_adj = dd_q;
    for (int i = 0; i < VD; i++)
      dd_adj[DATA_W+4*i +: 4] = dd_q[DATA_W+4*i +: 4] >= 4'd5 ? dd_q[DATA_W+4*i +: 4] + 4'd3 : dd_q[DATA_W+4*i +: 4];
  end
  // Digit d takes its nibble from the captured operand (hex/BCD) or the dabble result (decimal)
  for (genvar d = 0; d < VD; d++) begin : g_dig
    logic [3:0] op_nib, nib;
    logic [6:0] glyph;
    if (d < HD) begin : g_op
      assign op_nib = op_q[4*d +: 4];
    end else begin : g_no_op
      assign op_nib = 4'd0;
    end
    assign nib = tag_mode_q == DEC ? dd_q[DATA_W+4*d +: 4] :
                 (tag_mode_q == BCD && op_nib > 4'd9) ? 4'd9 : op_nib;
    seg7_glyph u_glyph (.nib(nib), .glyph(glyph));
    assign val_seg[d] = tag_mode_q == DEC ? (dec_ovf ? GLYPH_DASH : glyph) :
                        (tag_mode_q != OFF && d < HD) ? glyph : GLYPH_BLANK;
  end
  always_comb begin
    mode_d     = btn == BTN_HEX ? HEX : btn == BTN_DEC ? DEC : btn == BTN_BCD ? BCD : mode_q;
    state_d    = state_q;
    tag_vld_d  = tag_vld_q;
    tag_mode_d = tag_mode_q;
    op_d       = op_q;
    dd_d       = dd_q;
    cnt_d      = cnt_q;
    seg_d      = seg_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: if (changed) begin
        tag_vld_d  = 1'b1;
        tag_mode_d = mode_q;
        op_d       = sw_q;
        dd_d       = PW'(sw_q);
        cnt_d      = '0;
        state_d    = mode_q == DEC ? CONV : LOAD;
      end
      CONV: if (changed) begin
        state_d = IDLE;
      end else begin
        dd_d    = dd_adj << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DATA_W - 1) ? LOAD : CONV;
      end
      LOAD: begin
        seg_d   = {prefix, val_seg};
        ovf_d   = tag_mode_q == DEC ? dec_ovf : (tag_mode_q == BCD && bcd_ovf);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= OFF;
      sw_q       <= '0;
      state_q    <= IDLE;
      tag_vld_q  <= 1'b0;
      tag_mode_q <= OFF;
      op_q       <= '0;
      dd_q       <= '0;
      cnt_q      <= '0;
      seg_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      sw_q       <= sw;
      state_q    <= state_d;
      tag_vld_q  <= tag_vld_d;
      tag_mode_q <= tag_mode_d;
      op_q       <= op_d;
      dd_q       <= dd_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      ovf_q      <= ovf_d;
    end
  end
  assign seg      = ACTIVE_LOW ? ~seg_q : seg_q;
  assign busy     = state_q != IDLE;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_multi_code_display_ctrl.sv
// tb_multi_code_display_ctrl: vector table, hand corner sequences and random model check
module tb_multi_code_display_ctrl;
  localparam logic [6:0] GL [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  localparam logic [6:0] GH = 7'b1110110, GD = 7'b1011110, GB = 7'b1111100, GDASH = 7'b1000000, GBL = 7'b0;
  logic clk = 0, rst = 1;
  logic [2:0] btn = 3'b111;
  logic [7:0] sw = 8'h00;
  logic [27:0] seg4, act4;
  logic [20:0] seg3, act3;
  logic busy4, ovf4, busy3, ovf3;
  int n_checks = 0, n_fail = 0;
  assign act4 = ~seg4;
  assign act3 = ~seg3;
  always #5 clk = ~clk;
  multi_code_display_ctrl #(.DATA_W(8), .NUM_DIGITS(4), .ACTIVE_LOW(1)) u_dut4 (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .seg(seg4), .busy(busy4), .overflow(ovf4));
  multi_code_display_ctrl #(.DATA_W(8), .NUM_DIGITS(3), .ACTIVE_LOW(1)) u_dut3 (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .seg(seg3), .busy(busy3), .overflow(ovf3));
  typedef struct {
    logic [2:0]  b;
    logic [7:0]  v;
    logic [27:0] seg;
    logic        ovf;
    int          lat;
  } vec_t;
  vec_t vec [14];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  // Reference: mode 0 OFF, 1 HEX, 2 DEC, 3 BCD; returns {overflow, active-high segments}
  function automatic logic [28:0] model(input int m, input int v, input int nd);
    logic [27:0] s;
    logic o;
    int lim, p, nib;
    s = '0;
    lim = 1;
    for (int i = 0; i < nd - 1; i++) lim = lim * 10;
    p = 1;
    for (int d = 0; d < nd - 1; d++) begin
      nib = (v >> (4 * d)) & 15;
      if (m == 1 && d < 2) s[7*d +: 7] = GL[nib];
      else if (m == 2) s[7*d +: 7] = v >= lim ? GDASH : GL[(v / p) % 10];
      else if (m == 3 && d < 2) s[7*d +: 7] = GL[nib > 9 ? 9 : nib];
      p = p * 10;
    end
    s[7*(nd-1) +: 7] = m == 1 ? GH : m == 2 ? GD : m == 3 ? GB : GBL;
    o = (m == 2 && v >= lim) || (m == 3 && ((v & 15) > 9 || (v >> 4) > 9));
    return {o, s};
  endfunction
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [27:0] prev;
    logic [28:0] r;
    logic [2:0] btns [6];
    logic saw;
    int m;
    btns = '{3'b110, 3'b101, 3'b011, 3'b111, 3'b000, 3'b100};
    vec[0]  = '{3'b110, 8'hA7, {GH, GBL, GL[10], GL[7]}, 1'b0, 2};
    vec[1]  = '{3'b101, 8'd255, {GD, GL[2], GL[5], GL[5]}, 1'b0, 10};
    vec[2]  = '{3'b111, 8'd7, {GD, GL[0], GL[0], GL[7]}, 1'b0, 10};
    vec[3]  = '{3'b011, 8'h4C, {GB, GBL, GL[4], GL[9]}, 1'b1, 2};
    vec[4]  = '{3'b111, 8'h38, {GB, GBL, GL[3], GL[8]}, 1'b0, 2};
    vec[5]  = '{3'b110, 8'h00, {GH, GBL, GL[0], GL[0]}, 1'b0, 2};
    vec[6]  = '{3'b101, 8'd99, {GD, GL[0], GL[9], GL[9]}, 1'b0, 10};
    vec[7]  = '{3'b000, 8'd100, {GD, GL[1], GL[0], GL[0]}, 1'b0, 10};
    vec[8]  = '{3'b100, 8'h5F, {GD, GL[0], GL[9], GL[5]}, 1'b0, 10};
    vec[9]  = '{3'b110, 8'hF0, {GH, GBL, GL[15], GL[0]}, 1'b0, 2};
    vec[10] = '{3'b000, 8'h12, {GH, GBL, GL[1], GL[2]}, 1'b0, 2};
    vec[11] = '{3'b100, 8'h3B, {GH, GBL, GL[3], GL[11]}, 1'b0, 2};
    vec[12] = '{3'b011, 8'hA9, {GB, GBL, GL[9], GL[9]}, 1'b1, 2};
    vec[13] = '{3'b011, 8'h09, {GB, GBL, GL[0], GL[9]}, 1'b0, 2};
    repeat (2) @(negedge clk);
    check("rst seg4", seg4, 28'hFFFFFFF);
    check("rst seg3", seg3, 21'h1FFFFF);
    check("rst busy", busy4, 0);
    check("rst ovf", ovf4, 0);
    rst = 0;
    repeat (5) @(negedge clk);
    check("off seg4", seg4, 28'hFFFFFFF);
    check("off busy", busy4, 0);
    prev = '0;
    for (int i = 0; i < 14; i++) begin
      btn = vec[i].b;
      sw = vec[i].v;
      for (int k = 1; k <= vec[i].lat + 1; k++) begin
        @(negedge clk);
        btn = 3'b111;
        check($sformatf("v%0d busy k%0d", i, k), busy4, k >= 2 && k <= vec[i].lat);
        if (k == vec[i].lat) check($sformatf("v%0d seg hold", i), act4, prev);
      end
      check($sformatf("v%0d seg", i), act4, vec[i].seg);
      check($sformatf("v%0d ovf", i), ovf4, vec[i].ovf);
      prev = vec[i].seg;
      repeat (2) @(negedge clk);
    end
    btn = 3'b101;
    sw = 8'd200;
    saw = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      btn = 3'b111;
      if (k == 4) sw = 8'd45;
      if (act4 == {GD, GL[2], GL[0], GL[0]}) saw = 1;
    end
    check("abort stale shown", saw, 0);
    check("abort seg", act4, {GD, GL[0], GL[4], GL[5]});
    check("abort ovf", ovf4, 0);
    sw = 8'd123;
    repeat (14) @(negedge clk);
    check("nd3 seg", act3, {GD, GDASH, GDASH});
    check("nd3 ovf", ovf3, 1);
    check("nd4 123 seg", act4, {GD, GL[1], GL[2], GL[3]});
    check("nd4 123 ovf", ovf4, 0);
    m = 2;
    for (int i = 0; i < 40; i++) begin
      btn = btns[$urandom_range(0, 5)];
      sw = 8'($urandom_range(0, 255));
      m = btn == 3'b110 ? 1 : btn == 3'b101 ? 2 : btn == 3'b011 ? 3 : m;
      @(negedge clk);
      btn = 3'b111;
      repeat (13) @(negedge clk);
      r = model(m, int'(sw), 4);
      check($sformatf("rnd%0d seg4 sw=%0h", i, sw), act4, r[27:0]);
      check($sformatf("rnd%0d ovf4", i), ovf4, r[28]);
      r = model(m, int'(sw), 3);
      check($sformatf("rnd%0d seg3", i), act3, r[20:0]);
      check($sformatf("rnd%0d ovf3", i), ovf3, r[28]);
      check($sformatf("rnd%0d busy", i), busy4, 0);
    end
    btn = 3'b101;
    sw = (sw == 8'd77) ? 8'd78 : 8'd77;
    @(negedge clk);
    btn = 3'b111;
    repeat (2) @(negedge clk);
    check("midconv busy", busy4, 1);
    rst = 1;
    @(negedge clk);
    check("midconv rst seg", seg4, 28'hFFFFFFF);
    check("midconv rst busy", busy4, 0);
    check("midconv rst ovf", ovf4, 0);
    rst = 0;
    repeat (15) @(negedge clk);
    check("after rst seg", seg4, 28'hFFFFFFF);
    check("after rst busy", busy4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
